// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_ctrl_pkg
// Brief   : Opcode, ALU/PC mux encodings, state encoding and control-word type
//           shared by the multi-cycle MIPS sequencing controller.
// Revision: 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] ALU_SRC_B_RT      = 2'b00;
    localparam logic [1:0] ALU_SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] ALU_SRC_B_IMM     = 2'b10;
    localparam logic [1:0] ALU_SRC_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_RTYPEEX = 4'd7,
        S_RTYPEWB = 4'd8,
        S_BEQEX   = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JEX     = 4'd12
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       illegal_op;
        logic       mem_timeout;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_fsm_if.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_control_fsm_if
// Brief   : Opcode/memory-handshake inputs and datapath control lines of the
//           multi-cycle controller. master = controller, slave = datapath.
// Revision: 1.0 - initial release
// ============================================================================
interface multicycle_control_fsm_if;

    logic [5:0] instr_op;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_timeout;

    modport master (
        input  instr_op, mem_ready,
        output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, instr_done, illegal_op, mem_timeout
    );

    modport slave (
        output instr_op, mem_ready,
        input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, instr_done, illegal_op, mem_timeout
    );

endinterface
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module  : mem_wait_timer
// Brief   : Counts consecutive memory wait cycles; expired_o flags the last
//           cycle a memory state may wait before it must abort.
// Revision: 1.0 - initial release
// ============================================================================
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear_i,
    input  wire logic en_i,
    output logic      expired_o
);

    logic [CNT_W-1:0] cnt_q;

    // clear dominates so the count never runs past MEM_TIMEOUT-1
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_control_fsm
// Brief   : Multi-cycle MIPS sequencing controller with memory ready stalls
//           and wait timeout abort.
// Revision: 1.0 - initial release
// ============================================================================
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    multicycle_control_fsm_if.master  bus
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;

    logic in_mem_state;
    logic wait_en;
    logic wait_clr;
    logic wait_expired;
    logic timeout;

    assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                          (state_q == S_MEMWR);
    assign wait_en      = in_mem_state && !bus.mem_ready;
    assign timeout      = wait_en && wait_expired;
    // restart the count on every completion, abort or exit from a memory state
    assign wait_clr     = !wait_en || timeout;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_mem_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (wait_clr),
        .en_i      (wait_en),
        .expired_o (wait_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                case (bus.instr_op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (bus.instr_op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (bus.mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout) begin
                    state_d = S_FETCH;
                end
            end
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR: begin
                if (bus.mem_ready || timeout) begin
                    state_d = S_FETCH;
                end
            end
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_RTYPEWB: state_d = S_FETCH;
            S_BEQEX:   state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            S_JEX:     state_d = S_FETCH;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = ALU_SRC_B_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.pc_source = PC_SRC_ALU;
                ctrl.ir_write  = bus.mem_ready;
                ctrl.pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = ALU_SRC_B_IMM_SH2;
                ctrl.alu_op     = ALU_OP_ADD;
                ctrl.illegal_op = !is_legal_op(bus.instr_op);
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALU_SRC_B_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = bus.mem_ready;
            end
            S_RTYPEEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALU_SRC_B_RT;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            S_RTYPEWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BEQEX: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = ALU_SRC_B_RT;
                ctrl.alu_op        = ALU_OP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_SRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALU_SRC_B_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JEX: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PC_SRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
        ctrl.mem_timeout = timeout;
        // reset silences every write enable in the cycle it is raised
        if (rst) begin
            ctrl = '0;
        end
    end

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.i_or_d        = ctrl.i_or_d;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.instr_done    = ctrl.instr_done;
    assign bus.illegal_op    = ctrl.illegal_op;
    assign bus.mem_timeout   = ctrl.mem_timeout;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module  : tb_multicycle_control_fsm
// Brief   : Self-checking bench for multicycle_control_fsm with a per-
//           instruction behavioural model of latencies and control activity.
// Revision: 1.0 - initial release
// ============================================================================
module tb_multicycle_control_fsm;
    import mips_ctrl_pkg::*;

    localparam int MEM_TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] all_outs();
        return {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.i_or_d,
                bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_dst,
                bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.instr_done, bus.illegal_op, bus.mem_timeout};
    endfunction

    // Leaves the DUT in IDLE, sampled at the negedge; next posedge enters FETCH.
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One instruction from FETCH to completion. fw = FETCH wait cycles,
    // mw = wait cycles of the data access (lw/sw only).
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input string tag);
        int  got [17];
        int  exp [17];
        string nm [17];
        int  cyc, acc, wl;
        bit  inacc, done, is_lw, is_sw, is_r, is_beq, is_addi, is_j, legal;
        nm = '{"latency", "mem_read", "mem_write", "i_or_d", "ir_write", "pc_write",
               "pc_write_cond", "reg_write", "mem_to_reg", "reg_dst", "aluop_funct",
               "aluop_sub", "instr_done", "illegal_op", "mem_timeout", "pc_source", "first_fetch"};
        foreach (got[i]) got[i] = 0;
        is_lw = (op == 6'b100011); is_sw = (op == 6'b101011); is_r = (op == 6'b000000);
        is_beq = (op == 6'b000100); is_addi = (op == 6'b001000); is_j = (op == 6'b000010);
        legal = is_lw | is_sw | is_r | is_beq | is_addi | is_j;
        // reference model: zero-wait latency table plus one cycle per wait
        exp[0]  = !legal ? 2 + fw :
                  is_lw ? 5 + fw + mw : is_sw ? 4 + fw + mw : (is_r || is_addi) ? 4 + fw : 3 + fw;
        exp[1]  = fw + 1 + (is_lw ? mw + 1 : 0);
        exp[2]  = is_sw ? mw + 1 : 0;
        exp[3]  = (is_lw || is_sw) ? mw + 1 : 0;
        exp[4]  = 1;
        exp[5]  = is_j ? 2 : 1;
        exp[6]  = is_beq ? 1 : 0;
        exp[7]  = (is_lw || is_r || is_addi) ? 1 : 0;
        exp[8]  = is_lw ? 1 : 0;
        exp[9]  = is_r ? 1 : 0;
        exp[10] = is_r ? 1 : 0;
        exp[11] = is_beq ? 1 : 0;
        exp[12] = legal ? 1 : 0;
        exp[13] = legal ? 0 : 1;
        exp[14] = 0;
        exp[15] = 0;
        exp[16] = 1;
        cyc = 0; acc = 0; wl = 0; inacc = 0; done = 0;
        while (!done && cyc < 100) begin
            @(posedge clk);
            if (inacc) begin
                if (bus.mem_ready) inacc = 0;
                else wl--;
            end
            #1;
            bus.instr_op = op;
            if (!inacc && (bus.mem_read || bus.mem_write)) begin
                inacc = 1;
                wl = (acc == 0) ? fw : mw;
                acc++;
            end
            bus.mem_ready = inacc && (wl == 0);
            @(negedge clk);
            if (cyc == 0 && bus.mem_read && !bus.i_or_d) got[16] = 1;
            got[1]  += int'(bus.mem_read);
            got[2]  += int'(bus.mem_write);
            got[3]  += int'(bus.i_or_d);
            got[4]  += int'(bus.ir_write);
            got[5]  += int'(bus.pc_write);
            got[6]  += int'(bus.pc_write_cond);
            got[7]  += int'(bus.reg_write);
            got[8]  += int'(bus.mem_to_reg);
            got[9]  += int'(bus.reg_dst);
            got[10] += int'(bus.alu_op == 2'b10);
            got[11] += int'(bus.alu_op == 2'b01);
            got[12] += int'(bus.instr_done);
            got[13] += int'(bus.illegal_op);
            got[14] += int'(bus.mem_timeout);
            if ((bus.pc_write_cond && bus.pc_source != 2'b01) ||
                (bus.ir_write && bus.pc_source != 2'b00) ||
                (bus.pc_write && !bus.ir_write && bus.pc_source != 2'b10))
                got[15]++;
            cyc++;
            if (bus.instr_done || bus.illegal_op) done = 1;
        end
        got[0] = cyc;
        for (int k = 0; k < 17; k++) begin
            n_tests++;
            if (got[k] !== exp[k]) begin
                n_fail++;
                $display("FAIL %s op=%b fw=%0d mw=%0d %s: got %0d expected %0d",
                         tag, op, fw, mw, nm[k], got[k], exp[k]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mem_ready = 1'b0;
        bus.instr_op = 6'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i == 2) rst = 1'b0;
            @(negedge clk);
            n_tests++;
            if (all_outs() !== 19'd0) begin
                n_fail++;
                $display("FAIL reset_outs cycle %0d: got %h expected 0", i, all_outs());
            end
        end
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (bus.mem_read !== 1'b1 || bus.i_or_d !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fetch: mem_read=%b i_or_d=%b expected 1/0", bus.mem_read, bus.i_or_d);
        end
        do_reset();
    endtask

    task automatic test_lw();
        run_instr(OP_LW, 0, 0, "lw");
    endtask

    task automatic test_back_to_back();
        run_instr(OP_RTYPE, 0, 0, "b2b_r");
        run_instr(OP_BEQ, 0, 0, "b2b_beq");
        run_instr(OP_J, 0, 0, "b2b_j");
    endtask

    task automatic test_sw_wait();
        run_instr(OP_SW, 0, 3, "sw_wait");
        run_instr(OP_ADDI, 2, 0, "after_sw");
    endtask

    task automatic test_fetch_timeout();
        int first_to, n_to, n_ir, n_nofetch;
        first_to = 0; n_to = 0; n_ir = 0; n_nofetch = 0;
        do_reset();
        for (int c = 1; c <= MEM_TIMEOUT; c++) begin
            @(posedge clk); #1;
            bus.mem_ready = 1'b0;
            bus.instr_op = OP_ADDI;
            @(negedge clk);
            if (bus.mem_timeout) begin
                if (first_to == 0) first_to = c;
                n_to++;
            end
            n_ir += int'(bus.ir_write);
            n_nofetch += int'(!bus.mem_read);
        end
        n_tests++;
        if (first_to !== MEM_TIMEOUT || n_to !== 1) begin
            n_fail++;
            $display("FAIL fetch_timeout: pulse at cycle %0d count %0d expected cycle %0d count 1",
                     first_to, n_to, MEM_TIMEOUT);
        end
        n_tests++;
        if (n_ir !== 0 || n_nofetch !== 0) begin
            n_fail++;
            $display("FAIL fetch_timeout_writes: ir_write cycles %0d non-fetch cycles %0d expected 0/0",
                     n_ir, n_nofetch);
        end
        // mem_ready on the would-be timeout cycle completes normally
        run_instr(OP_ADDI, MEM_TIMEOUT - 1, 0, "retry_after_to");
    endtask

    task automatic test_memrd_timeout();
        int to_cyc, n_rw, n_done, c;
        to_cyc = 0; n_rw = 0; n_done = 0; c = 0;
        do_reset();
        while (to_cyc == 0 && c < 40) begin
            @(posedge clk); #1;
            bus.instr_op = OP_LW;
            bus.mem_ready = bus.mem_read && !bus.i_or_d;
            @(negedge clk);
            c++;
            n_rw += int'(bus.reg_write);
            n_done += int'(bus.instr_done);
            if (bus.mem_timeout) to_cyc = c;
        end
        n_tests++;
        if (to_cyc !== 3 + MEM_TIMEOUT || n_rw !== 0 || n_done !== 0) begin
            n_fail++;
            $display("FAIL memrd_timeout: cycle %0d reg_write %0d instr_done %0d expected %0d/0/0",
                     to_cyc, n_rw, n_done, 3 + MEM_TIMEOUT);
        end
        run_instr(OP_LW, 0, MEM_TIMEOUT - 1, "lw_after_to");
    endtask

    task automatic test_illegal();
        run_instr(6'b111111, 0, 0, "illegal");
        run_instr(OP_SW, 0, 0, "after_illegal");
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 0;
        do_reset();
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk); #1;
            bus.instr_op = OP_LW;
            bus.mem_ready = bus.mem_read && !bus.i_or_d;
            @(negedge clk);
            if (bus.mem_read && bus.i_or_d) seen = 1;
        end
        bus.mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        n_tests++;
        if (!seen || all_outs() !== 19'd0) begin
            n_fail++;
            $display("FAIL rst_in_memrd: reached=%0d outs=%h expected 1/0", seen, all_outs());
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (all_outs() !== 19'd0) begin
            n_fail++;
            $display("FAIL idle_after_rst: got %h expected 0", all_outs());
        end
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (bus.mem_read !== 1'b1 || bus.i_or_d !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_after_rst: mem_read=%b i_or_d=%b expected 1/0", bus.mem_read, bus.i_or_d);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic [5:0] ops [6];
        logic [5:0] op;
        ops = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J};
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            else op = ops[$urandom_range(0, 5)];
            run_instr(op, int'($urandom_range(0, MEM_TIMEOUT - 1)),
                      int'($urandom_range(0, MEM_TIMEOUT - 1)), "random");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.instr_op = 6'b0;
        bus.mem_ready = 1'b0;
        test_reset();
        test_lw();
        test_back_to_back();
        test_sw_wait();
        test_fetch_timeout();
        test_memrd_timeout();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
